fir_seq_ctrl: RTL and testbench

Sequencer placed in front of the 4-tap streaming FIR filter. It paces source samples into the filter at a programmable sample rate using a clock-divider tick. It runs bursts of N samples or continuous mode, then flushes the filter delay line with zero samples. It drives the filter's data, valid and enable inputs and reports status: busy, done, count and missed slots.

---
 rtl/fir_seq_ctrl_if.sv | 35 +++
 rtl/fir_seq_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_fir_seq_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_seq_ctrl_if.sv
// Sample stream bundle between the FIR sequencer, its source, and the FIR filter.
// Signal names and i_/o_ prefixes are from the sequencer's point of view.
// The master modport is the sequencer; the slave modport is the environment
// (source, filter and downstream ready).
interface fir_seq_ctrl_if #(
    parameter int WW_INPUT = 8
) ();
    logic [WW_INPUT-1:0] i_src_data;
    logic                i_src_dv;
    logic                o_src_rfd;
    logic                i_snk_rfd;
    logic [WW_INPUT-1:0] o_fir_data;
    logic                o_fir_dv;
    logic                o_fir_en;

    modport master (
        input  i_src_data,
        input  i_src_dv,
        input  i_snk_rfd,
        output o_src_rfd,
        output o_fir_data,
        output o_fir_dv,
        output o_fir_en
    );

    modport slave (
        output i_src_data,
        output i_src_dv,
        output i_snk_rfd,
        input  o_src_rfd,
        input  o_fir_data,
        input  o_fir_dv,
        input  o_fir_en
    );
endinterface

// File: rtl/fir_seq_ctrl.sv
// FIR input sequencer.
// Paces source samples into a 4-tap FIR at one slot per divider period, runs a
// counted burst or a continuous stream, then pushes FLUSH_LEN zero samples to
// drain the filter delay line. At most one slot is ever owed; a slot tick that
// lands on an owed slot is recorded in the sticky underrun flag.
// Hand-off to the filter is combinational so a sample is issued in the same
// cycle that source and sink are both ready.
module fir_seq_ctrl #(
    parameter int WW_INPUT  = 8,
    parameter int WW_DIV    = 16,
    parameter int WW_CNT    = 16,
    parameter int FLUSH_LEN = 3
) (
    input  logic                clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic                i_flush,
    input  logic                i_abort,
    input  logic [WW_DIV-1:0]   i_div,
    input  logic [WW_CNT-1:0]   i_nsamples,
    fir_seq_ctrl_if.master      bus,
    output logic                o_busy,
    output logic                o_done,
    output logic [WW_CNT-1:0]   o_count,
    output logic                o_underrun
);

    // Flush counter only needs to reach FLUSH_LEN-1 before the run completes.
    localparam int WW_FCNT = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

    localparam logic [WW_DIV-1:0]  DIV_ZERO   = {WW_DIV{1'b0}};
    localparam logic [WW_DIV-1:0]  DIV_ONE    = WW_DIV'(1);
    localparam logic [WW_CNT-1:0]  CNT_ZERO   = {WW_CNT{1'b0}};
    localparam logic [WW_CNT-1:0]  CNT_ONE    = WW_CNT'(1);
    localparam logic [WW_FCNT-1:0] FCNT_ZERO  = {WW_FCNT{1'b0}};
    localparam logic [WW_FCNT-1:0] FCNT_ONE   = WW_FCNT'(1);
    localparam logic [WW_FCNT-1:0] FCNT_LAST  = WW_FCNT'(FLUSH_LEN - 1);
    localparam logic [WW_INPUT-1:0] DATA_ZERO = {WW_INPUT{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic [WW_DIV-1:0]   r_div_cnt;
    logic                r_pend;
    logic [WW_FCNT-1:0]  r_fcnt;
    logic [WW_CNT-1:0]   r_count;
    logic                r_underrun;
    logic                r_busy;
    logic                r_done;

    logic                w_in_run;
    logic                w_in_flush;
    logic                w_active;
    logic                w_tick;
    logic                w_issue;
    logic [WW_CNT-1:0]   w_count_inc;
    logic                w_last;

    assign w_in_run    = (r_state == ST_RUN);
    assign w_in_flush  = (r_state == ST_FLUSH);
    assign w_active    = w_in_run | w_in_flush;
    // The divider only produces slot ticks while pacing samples.
    assign w_tick      = w_active & (r_div_cnt == DIV_ZERO);
    assign w_count_inc = r_count + CNT_ONE;
    // Burst completes on the issue that brings the count up to the burst length.
    assign w_last      = (i_nsamples != CNT_ZERO) & (w_count_inc == i_nsamples);

    // Issue decision: an owed slot meets a ready sink (and real data while running).
    always_comb begin
        w_issue = 1'b0;
        case (r_state)
            ST_RUN:   w_issue = r_pend & bus.i_snk_rfd & bus.i_src_dv;
            ST_FLUSH: w_issue = r_pend & bus.i_snk_rfd;
            default:  w_issue = 1'b0;
        endcase
    end

    // Filter-side and source-side stream outputs; zeros are fed during flush.
    always_comb begin
        bus.o_src_rfd = w_in_run & r_pend & bus.i_snk_rfd;
        bus.o_fir_dv  = w_issue;
        bus.o_fir_en  = w_issue;
        if (w_in_run) begin
            bus.o_fir_data = bus.i_src_data;
        end else begin
            bus.o_fir_data = DATA_ZERO;
        end
    end

    // Sequencer FSM with divider, slot flag, counters and registered status.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_div_cnt  <= DIV_ZERO;
            r_pend     <= 1'b0;
            r_fcnt     <= FCNT_ZERO;
            r_count    <= CNT_ZERO;
            r_underrun <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else if (i_abort) begin
            // Abort drops everything in flight; count and underrun are kept
            // so software can still inspect the interrupted run.
            r_state <= ST_IDLE;
            r_pend  <= 1'b0;
            r_fcnt  <= FCNT_ZERO;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            // Slot pacing. Later assignments in the state case below take
            // precedence when a state change restarts the slot logic.
            if (w_active) begin
                if (w_tick) begin
                    r_div_cnt <= i_div;
                    r_pend    <= 1'b1;
                    if (r_pend && !w_issue) begin
                        r_underrun <= 1'b1;
                    end
                end else begin
                    r_div_cnt <= r_div_cnt - DIV_ONE;
                    r_pend    <= r_pend & ~w_issue;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state    <= ST_RUN;
                        r_busy     <= 1'b1;
                        r_div_cnt  <= i_div;
                        r_pend     <= 1'b0;
                        r_count    <= CNT_ZERO;
                        r_underrun <= 1'b0;
                    end else if (i_flush) begin
                        r_state   <= ST_FLUSH;
                        r_busy    <= 1'b1;
                        r_div_cnt <= i_div;
                        r_pend    <= 1'b0;
                        r_fcnt    <= FCNT_ZERO;
                    end
                end
                ST_RUN: begin
                    // A new start is ignored while running; an early flush
                    // still lets a same-cycle transfer complete.
                    if (w_issue) begin
                        r_count <= w_count_inc;
                    end
                    if (i_flush || (w_issue && w_last)) begin
                        // Divider keeps its phase across the switch to flush.
                        r_state <= ST_FLUSH;
                        r_pend  <= 1'b0;
                        r_fcnt  <= FCNT_ZERO;
                    end
                end
                ST_FLUSH: begin
                    if (w_issue) begin
                        if (r_fcnt == FCNT_LAST) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_fcnt <= r_fcnt + FCNT_ONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_count    = r_count;
    assign o_underrun = r_underrun;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Bench for fir_seq_ctrl: table of counted bursts, hand-written corner
// sequences, and a randomized run against a behavioural reference model.
module tb_fir_seq_ctrl;
    localparam int WI = 8;
    localparam int WD = 16;
    localparam int WC = 16;
    localparam int FL = 3;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_FLUSH = 2;
    localparam int M_DONE  = 3;

    logic          clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic          i_flush = 1'b0;
    logic          i_abort = 1'b0;
    logic [WD-1:0] i_div = '0;
    logic [WC-1:0] i_nsamples = '0;
    logic          o_busy;
    logic          o_done;
    logic [WC-1:0] o_count;
    logic          o_underrun;

    fir_seq_ctrl_if #(.WW_INPUT(WI)) u_if ();

    fir_seq_ctrl #(
        .WW_INPUT(WI), .WW_DIV(WD), .WW_CNT(WC), .FLUSH_LEN(FL)
    ) dut (
        .clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_flush(i_flush),
        .i_abort(i_abort), .i_div(i_div), .i_nsamples(i_nsamples), .bus(u_if),
        .o_busy(o_busy), .o_done(o_done), .o_count(o_count), .o_underrun(o_underrun)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Output snapshot layout: [29]src_rfd [28:21]fir_data [20]fir_dv [19]fir_en
    // [18]busy [17]done [16:1]count [0]underrun
    logic [29:0] snap;

    // Reference model state, kept in plain integers.
    int m_mode, m_since, m_tgt, m_count, m_flushed;
    bit m_owed, m_underrun;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [29:0] dut_out();
        return {u_if.o_src_rfd, u_if.o_fir_data, u_if.o_fir_dv, u_if.o_fir_en,
                o_busy, o_done, o_count, o_underrun};
    endfunction

    function automatic void model_reset();
        m_mode = M_IDLE; m_since = 0; m_tgt = 0; m_count = 0;
        m_flushed = 0; m_owed = 1'b0; m_underrun = 1'b0;
    endfunction

    function automatic logic [29:0] model_out();
        bit run = (m_mode == M_RUN);
        bit fl  = (m_mode == M_FLUSH);
        bit iss = m_owed && u_if.i_snk_rfd && (run ? u_if.i_src_dv : fl);
        logic [WI-1:0] data = run ? u_if.i_src_data : 8'd0;
        logic [WC-1:0] cnt = WC'(m_count);
        return {run && m_owed && u_if.i_snk_rfd, data, iss, iss,
                m_mode != M_IDLE, m_mode == M_DONE, cnt, m_underrun};
    endfunction

    // One clock of the specified behaviour, using the inputs of this cycle.
    function automatic void model_step();
        bit run  = (m_mode == M_RUN);
        bit fl   = (m_mode == M_FLUSH);
        bit iss  = m_owed && u_if.i_snk_rfd && (run ? u_if.i_src_dv : fl);
        bit tick = (run || fl) && (m_since == m_tgt);
        if (!i_rst_n) begin
            model_reset();
            return;
        end
        if (i_abort) begin
            m_mode = M_IDLE; m_owed = 1'b0; m_flushed = 0;
            return;
        end
        case (m_mode)
            M_IDLE: begin
                if (i_start) begin
                    m_mode = M_RUN; m_count = 0; m_underrun = 1'b0;
                    m_since = 0; m_tgt = int'(i_div); m_owed = 1'b0;
                end else if (i_flush) begin
                    m_mode = M_FLUSH; m_flushed = 0;
                    m_since = 0; m_tgt = int'(i_div); m_owed = 1'b0;
                end
            end
            M_RUN, M_FLUSH: begin
                if (tick) begin
                    if (m_owed && !iss) m_underrun = 1'b1;
                    m_owed = 1'b1; m_since = 0; m_tgt = int'(i_div);
                end else begin
                    m_since++;
                    if (iss) m_owed = 1'b0;
                end
                if (run) begin
                    if (iss) m_count = (m_count + 1) % 65536;
                    if ((iss && i_nsamples != 0 && m_count == int'(i_nsamples)) || i_flush) begin
                        m_mode = M_FLUSH; m_owed = 1'b0; m_flushed = 0;
                    end
                end else if (iss) begin
                    m_flushed++;
                    if (m_flushed == FL) m_mode = M_DONE;
                end
            end
            default: m_mode = M_IDLE;
        endcase
    endfunction

    // Compare one cycle against the model, keep a snapshot, advance one clock.
    task automatic adv();
        logic [29:0] act;
        #2;
        act = dut_out();
        check("model", act, model_out());
        snap = act;
        model_step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int div;
        int nsamp;
        int flush_first;
        int done_rel;
        int exp_count;
    } burst_t;

    burst_t bt[4];

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int issued, dones;
        logic exp_dv;
        logic [WI-1:0] exp_data;
        bit got_done;

        // Times are relative to the first cycle after the start pulse.
        bt[0] = '{3, 4, 20, 29, 4};
        bt[1] = '{0, 5,  7, 10, 5};
        bt[2] = '{1, 2,  6, 11, 2};
        bt[3] = '{2, 1,  6, 13, 1};

        u_if.i_src_data = '0; u_if.i_src_dv = 1'b1; u_if.i_snk_rfd = 1'b1;
        model_reset();
        #1;
        check("reset_outputs", dut_out(), 0);
        @(posedge clk); #1;
        adv(); adv();
        i_rst_n = 1'b1;
        adv();

        // Counted bursts with no stalls.
        foreach (bt[r]) begin
            i_div = WD'(bt[r].div); i_nsamples = WC'(bt[r].nsamp);
            u_if.i_src_dv = 1'b1; u_if.i_snk_rfd = 1'b1;
            i_start = 1'b1; adv(); i_start = 1'b0;
            issued = 0; dones = 0;
            for (int rel = 0; rel <= bt[r].done_rel + 1; rel++) begin
                u_if.i_src_data = WI'(10 * (issued + 1));
                exp_dv = 1'b0; exp_data = '0;
                for (int k = 1; k <= bt[r].nsamp; k++)
                    if (rel == k * (bt[r].div + 1)) begin
                        exp_dv = 1'b1; exp_data = WI'(10 * k);
                    end
                for (int j = 0; j < FL; j++)
                    if (rel == bt[r].flush_first + j * (bt[r].div + 1)) exp_dv = 1'b1;
                adv();
                check("burst_dv", snap[20], exp_dv);
                if (exp_dv) begin
                    check("burst_data", snap[28:21], exp_data);
                    issued++;
                end
                if (snap[17]) begin
                    dones++;
                    check("burst_done_time", rel, bt[r].done_rel);
                end
            end
            check("burst_done_pulses", dones, 1);
            check("burst_count", snap[16:1], bt[r].exp_count);
            check("burst_underrun", snap[0], 0);
            check("burst_idle", snap[18], 0);
            adv();
        end

        // Source stall longer than the slot period.
        i_div = 16'd1; i_nsamples = 16'd6; u_if.i_snk_rfd = 1'b1; u_if.i_src_dv = 1'b1;
        i_start = 1'b1; adv(); i_start = 1'b0;
        for (int rel = 0; rel <= 12; rel++) begin
            u_if.i_src_dv = !(rel >= 5 && rel <= 9);
            u_if.i_src_data = WI'(rel + 100);
            adv();
            if (rel == 6) check("stall_src_rfd", snap[29], 1);
            if (rel == 7) check("stall_underrun_before", snap[0], 0);
            if (rel == 8) check("stall_underrun", snap[0], 1);
            if (rel == 9) check("stall_no_issue", snap[20], 0);
            if (rel == 10) begin
                check("stall_resume_dv", snap[20], 1);
                check("stall_resume_data", snap[28:21], 110);
            end
            if (rel == 11) begin
                check("stall_one_owed", snap[20], 0);
                check("stall_count", snap[16:1], 3);
            end
            if (rel == 12) check("stall_next_issue", snap[20], 1);
        end
        u_if.i_src_dv = 1'b1;
        i_abort = 1'b1; adv(); i_abort = 1'b0;
        adv();
        check("stall_abort_idle", snap[18], 0);

        // Sink backpressure shorter than the slot period.
        i_div = 16'd7; i_nsamples = 16'd2;
        i_start = 1'b1; adv(); i_start = 1'b0;
        for (int rel = 0; rel <= 12; rel++) begin
            u_if.i_snk_rfd = !(rel >= 8 && rel <= 10);
            adv();
            if (rel >= 8 && rel <= 10) begin
                check("bp_fir_en_low", snap[19], 0);
                check("bp_src_rfd_low", snap[29], 0);
            end
            if (rel == 11) begin
                check("bp_fir_en_resume", snap[19], 1);
                check("bp_src_rfd_resume", snap[29], 1);
            end
        end
        u_if.i_snk_rfd = 1'b1;
        got_done = 1'b0;
        for (int k = 0; k < 100 && !got_done; k++) begin
            adv();
            if (snap[17]) got_done = 1'b1;
        end
        check("bp_done_seen", got_done, 1);
        check("bp_underrun", snap[0], 0);
        check("bp_count", snap[16:1], 2);
        adv();

        // Continuous mode at one sample per clock, ended by a flush pulse.
        i_div = 16'd0; i_nsamples = 16'd0;
        i_start = 1'b1; adv(); i_start = 1'b0;
        for (int rel = 0; rel < 100; rel++) begin
            u_if.i_src_data = WI'($urandom);
            adv();
        end
        i_flush = 1'b1; adv(); i_flush = 1'b0;
        check("cont_count_pre", snap[16:1], 99);
        check("cont_last_issue", snap[20], 1);
        u_if.i_src_data = 8'hA5;
        adv();
        check("cont_count", snap[16:1], 100);
        check("cont_flush_gap", snap[20], 0);
        for (int j = 0; j < FL; j++) begin
            adv();
            check("cont_zero_dv", snap[20], 1);
            check("cont_zero_data", snap[28:21], 0);
        end
        adv();
        check("cont_done", snap[17], 1);
        adv();
        check("cont_idle", snap[18], 0);
        check("cont_done_once", snap[17], 0);

        // Flush from IDLE, aborted after the first zero sample.
        i_div = 16'd2;
        i_flush = 1'b1; adv(); i_flush = 1'b0;
        for (int rel = 0; rel <= 3; rel++) begin
            adv();
            check("abort_no_done", snap[17], 0);
        end
        check("abort_first_zero", snap[20], 1);
        i_abort = 1'b1; adv(); i_abort = 1'b0;
        check("abort_busy_before", snap[18], 1);
        adv();
        check("abort_idle", snap[18], 0);
        check("abort_no_done_after", snap[17], 0);
        check("abort_count_holds", snap[16:1], 100);
        i_div = 16'd1;
        i_start = 1'b1; adv(); i_start = 1'b0;
        adv();
        check("restart_count_clear", snap[16:1], 0);
        check("restart_busy", snap[18], 1);

        // Asynchronous reset in the middle of a run.
        for (int k = 0; k < 10; k++) adv();
        check("rst_pre_count", snap[16:1], 4);
        i_rst_n = 1'b0;
        #1;
        check("rst_async_outputs", dut_out(), 0);
        model_reset();
        adv(); adv();
        i_rst_n = 1'b1;
        adv();
        check("rst_release_idle", snap[18], 0);
        check("rst_release_count", snap[16:1], 0);

        // Randomized traffic checked cycle by cycle against the model.
        for (int t = 0; t < 4000; t++) begin
            if (m_mode == M_IDLE) begin
                i_start = ($urandom_range(0, 5) == 0);
                if (i_start) i_nsamples = WC'($urandom_range(0, 6));
            end else begin
                i_start = ($urandom_range(0, 40) == 0);
            end
            i_flush = !i_start && ($urandom_range(0, 50) == 0);
            i_abort = ($urandom_range(0, 150) == 0);
            i_div = WD'($urandom_range(0, 4));
            u_if.i_src_dv = ($urandom_range(0, 3) != 0);
            u_if.i_snk_rfd = ($urandom_range(0, 4) != 0);
            u_if.i_src_data = WI'($urandom);
            adv();
        end
        i_start = 1'b0; i_flush = 1'b0; i_abort = 1'b0;
        adv();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
